// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

    typedef enum logic {
        IDLE,
        TRANSMIT
    } state_t;

    localparam int unsigned BAUD_DIV_DEFAULT = 2604;
    localparam int unsigned FRAME_LEN        = 10;
    localparam int unsigned BAUD_CNT_W       = 12;

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable baud down-counter; tick marks the last clock of each bit period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic load,
    output logic tick
);

    localparam logic [BAUD_CNT_W-1:0] Reload = BAUD_CNT_W'(BAUD_DIV - 1);

    logic [BAUD_CNT_W-1:0] cnt_q;

    assign tick = en && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load || tick) begin
            cnt_q <= Reload;
        end else if (en) begin
            cnt_q <= cnt_q - BAUD_CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-deep holding register for gap-free streaming.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_rdy,
    output logic       tx_done
);

    localparam logic [3:0] LastBit = 4'(FRAME_LEN - 1);

    state_t     state_q;
    logic       tx_q;
    logic       rdy_q;
    logic       done_q;
    logic [7:0] hold_q;
    logic [8:0] shift_q;
    logic [3:0] bit_cnt_q;

    logic tick;
    logic frame_end;
    logic load;

    always_comb begin
        frame_end = (state_q == TRANSMIT) && tick && (bit_cnt_q == LastBit);
        // A new frame starts from idle, or straight out of a finishing frame.
        load = ((state_q == IDLE) && trmt) || (frame_end && (!rdy_q || trmt));
    end

    uart_baud_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state_q == TRANSMIT),
        .load (load),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            rdy_q     <= 1'b1;
            done_q    <= 1'b0;
            hold_q    <= '0;
            shift_q   <= '1;
            bit_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (trmt) begin
                        shift_q   <= {1'b1, tx_data};
                        tx_q      <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= TRANSMIT;
                    end
                end
                TRANSMIT: begin
                    if (frame_end) begin
                        done_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        if (!rdy_q) begin
                            shift_q <= {1'b1, hold_q};
                            tx_q    <= 1'b0;
                            rdy_q   <= 1'b1;
                        end else if (trmt) begin
                            shift_q <= {1'b1, tx_data};
                            tx_q    <= 1'b0;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        if (tick) begin
                            // Stop bit shifts in from the top behind the data bits.
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b1, shift_q[8:1]};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                        if (trmt && rdy_q) begin
                            hold_q <= tx_data;
                            rdy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    tx_q      <= 1'b1;
                    rdy_q     <= 1'b1;
                    bit_cnt_q <= '0;
                end
            endcase
        end
    end

    assign TX      = tx_q;
    assign tx_rdy  = rdy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: default-rate single frame plus randomized scenarios at BAUD_DIV=16.
module tb_uart_tx;

    localparam int BD_BIG   = 2604;
    localparam int BD_SMALL = 16;
    localparam int MAXN     = 26100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trmt;
    logic       sel;
    logic [7:0] tx_data;
    logic       tx_b, rdy_b, done_b;
    logic       tx_s, rdy_s, done_s;

    always #5 clk = ~clk;

    uart_tx #(.BAUD_DIV(BD_BIG)) u_big (
        .clk    (clk),
        .rst_n  (rst_n),
        .trmt   (trmt & sel),
        .tx_data(tx_data),
        .TX     (tx_b),
        .tx_rdy (rdy_b),
        .tx_done(done_b)
    );

    uart_tx #(.BAUD_DIV(BD_SMALL)) u_small (
        .clk    (clk),
        .rst_n  (rst_n),
        .trmt   (trmt & ~sel),
        .tx_data(tx_data),
        .TX     (tx_s),
        .tx_rdy (rdy_s),
        .tx_done(done_s)
    );

    int checks   = 0;
    int failures = 0;
    int bd;
    int rst_at;
    int first_bad;

    bit         ev_v   [0:MAXN];
    logic [7:0] ev_d   [0:MAXN];
    logic       obs_tx [0:MAXN];
    logic       obs_rdy[0:MAXN];
    logic       obs_done[0:MAXN];
    logic [7:0] exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        trmt  = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic clear_sched();
        for (int i = 0; i <= MAXN; i++) ev_v[i] = 1'b0;
        rst_at = -1;
        exp_q.delete();
    endtask

    // obs[j] is the DUT state just after edge j-1, edge 0 being the first event.
    task automatic run(input int n);
        for (int j = 0; j < n; j++) begin
            trmt    = ev_v[j];
            tx_data = ev_v[j] ? ev_d[j] : 8'($urandom);
            rst_n   = (j != rst_at);
            step();
            obs_tx[j+1]   = sel ? tx_b : tx_s;
            obs_rdy[j+1]  = sel ? rdy_b : rdy_s;
            obs_done[j+1] = sel ? done_b : done_s;
        end
        trmt  = 1'b0;
        rst_n = 1'b1;
    endtask

    // Reference: queued bytes go out as contiguous 10-bit frames starting at obs index 1.
    function automatic logic frame_bit(logic [7:0] b, int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    function automatic logic model_tx(int j);
        int fl = 10 * bd;
        int f  = (j - 1) / fl;
        if (f >= exp_q.size()) return 1'b1;
        return frame_bit(exp_q[f], ((j - 1) % fl) / bd);
    endfunction

    function automatic logic model_done(int j);
        int fl = 10 * bd;
        return (j > 1) && ((j - 1) % fl == 0) && ((j - 1) / fl <= exp_q.size());
    endfunction

    function automatic int tx_errs(int n);
        int e = 0;
        first_bad = 0;
        for (int j = 1; j <= n; j++) begin
            if (obs_tx[j] !== model_tx(j)) begin
                e++;
                if (first_bad == 0) first_bad = j;
            end
        end
        return e;
    endfunction

    function automatic int done_errs(int n);
        int e = 0;
        first_bad = 0;
        for (int j = 1; j <= n; j++) begin
            if (obs_done[j] !== model_done(j)) begin
                e++;
                if (first_bad == 0) first_bad = j;
            end
        end
        return e;
    endfunction

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0; trmt = 1'b1; tx_data = 8'hC3; sel = 1'b0;
        step();
        sel = 1'b1;
        step();
        trmt = 1'b0; rst_n = 1'b1; sel = 1'b0;
        checks++;
        if ({tx_s, rdy_s, done_s} !== 3'b110) begin
            failures++;
            $display("FAIL reset_small: got TX/rdy/done=%b required 110", {tx_s, rdy_s, done_s});
        end
        checks++;
        if ({tx_b, rdy_b, done_b} !== 3'b110) begin
            failures++;
            $display("FAIL reset_big: got TX/rdy/done=%b required 110", {tx_b, rdy_b, done_b});
        end
        for (int i = 0; i < 40; i++) begin
            step();
            if ({tx_s, rdy_s, done_s} !== 3'b110) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL trmt_in_reset: %0d non-idle cycles, required 0", bad);
        end
    endtask

    task automatic test_default_a5();
        int n, e, nd, fd;
        sel = 1'b1; bd = BD_BIG;
        do_reset(); clear_sched();
        ev_v[0] = 1'b1; ev_d[0] = 8'hA5; exp_q.push_back(8'hA5);
        n = 10 * bd + 4;
        run(n);
        checks++;
        if (obs_tx[1] !== 1'b0) begin
            failures++;
            $display("FAIL a5_start_latency: TX=%b at +1, required 0", obs_tx[1]);
        end
        e = tx_errs(n); checks++;
        if (e !== 0) begin
            failures++;
            $display("FAIL a5_tx_wave: %0d bad cycles, first at %0d, required 0", e, first_bad);
        end
        e = done_errs(n); checks++;
        if (e !== 0) begin
            failures++;
            $display("FAIL a5_done_wave: %0d bad cycles, first at %0d, required 0", e, first_bad);
        end
        nd = 0; fd = 0;
        for (int j = 1; j <= n; j++) if (obs_done[j] === 1'b1) begin nd++; if (fd == 0) fd = j; end
        checks++;
        if (nd !== 1 || fd !== 26041) begin
            failures++;
            $display("FAIL a5_done_pulse: count=%0d at=%0d, required count=1 at=26041", nd, fd);
        end
        e = 0;
        for (int j = 1; j <= n; j++) if (obs_rdy[j] !== 1'b1) e++;
        checks++;
        if (e !== 0) begin
            failures++;
            $display("FAIL a5_rdy: %0d cycles low, required 0", e);
        end
    endtask

    task automatic test_len16_00();
        int n, lows, fd;
        sel = 1'b0; bd = BD_SMALL;
        do_reset(); clear_sched();
        ev_v[0] = 1'b1; ev_d[0] = 8'h00; exp_q.push_back(8'h00);
        n = 200;
        run(n);
        lows = 0;
        for (int j = 1; j <= n; j++) if (obs_tx[j] === 1'b0) lows++;
        checks++;
        if (lows !== 144) begin
            failures++;
            $display("FAIL len16_low: TX low %0d clocks, required 144", lows);
        end
        checks++;
        if ({obs_tx[144], obs_tx[145]} !== 2'b01) begin
            failures++;
            $display("FAIL len16_edge: TX[144..145]=%b, required 01", {obs_tx[144], obs_tx[145]});
        end
        fd = 0;
        for (int j = n; j >= 1; j--) if (obs_done[j] === 1'b1) fd = j;
        checks++;
        if (fd !== 161) begin
            failures++;
            $display("FAIL len16_done: first tx_done at %0d, required 161", fd);
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0; bd = BD_SMALL;
        for (int it = 0; it < 5; it++) begin
            logic [7:0] a, b, c;
            int d1, d2, n, e;
            if (it == 0) begin
                a = 8'h55; b = 8'h0F; c = 8'hFF; d1 = 3 * bd + 5; d2 = 6 * bd;
            end else begin
                a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
                d1 = $urandom_range(10 * bd - 1, 1);
                d2 = $urandom_range(10 * bd, d1 + 1);
            end
            do_reset(); clear_sched();
            ev_v[0] = 1'b1;  ev_d[0] = a;
            ev_v[d1] = 1'b1; ev_d[d1] = b;
            ev_v[d2] = 1'b1; ev_d[d2] = c;
            exp_q.push_back(a); exp_q.push_back(b);
            n = 22 * bd;
            run(n);
            e = tx_errs(n); checks++;
            if (e !== 0) begin
                failures++;
                $display("FAIL b2b_tx_wave it=%0d: %0d bad cycles, first at %0d, required 0",
                         it, e, first_bad);
            end
            e = done_errs(n); checks++;
            if (e !== 0) begin
                failures++;
                $display("FAIL b2b_done it=%0d: %0d bad cycles, first at %0d, required 0",
                         it, e, first_bad);
            end
            e = 0;
            for (int j = 1; j <= n; j++)
                if (obs_rdy[j] !== !((j >= d1 + 1) && (j <= 10 * bd))) e++;
            checks++;
            if (e !== 0) begin
                failures++;
                $display("FAIL b2b_rdy it=%0d: %0d bad cycles, required 0", it, e);
            end
        end
    endtask

    task automatic test_frame_end_load();
        sel = 1'b0; bd = BD_SMALL;
        for (int it = 0; it < 4; it++) begin
            logic [7:0] a, b;
            int n, e;
            a = (it == 0) ? 8'h81 : 8'($urandom);
            b = (it == 0) ? 8'h3C : 8'($urandom);
            do_reset(); clear_sched();
            ev_v[0] = 1'b1;       ev_d[0] = a;
            ev_v[10 * bd] = 1'b1; ev_d[10 * bd] = b;
            exp_q.push_back(a); exp_q.push_back(b);
            n = 22 * bd;
            run(n);
            e = tx_errs(n); checks++;
            if (e !== 0) begin
                failures++;
                $display("FAIL fe_load_tx it=%0d: %0d bad cycles, first at %0d, required 0",
                         it, e, first_bad);
            end
            e = done_errs(n); checks++;
            if (e !== 0) begin
                failures++;
                $display("FAIL fe_load_done it=%0d: %0d bad cycles, first at %0d, required 0",
                         it, e, first_bad);
            end
            e = 0;
            for (int j = 1; j <= n; j++) if (obs_rdy[j] !== 1'b1) e++;
            checks++;
            if (e !== 0) begin
                failures++;
                $display("FAIL fe_load_rdy it=%0d: %0d cycles low, required 0", it, e);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int n, e, dh, r;
        sel = 1'b0; bd = BD_SMALL;
        do_reset(); clear_sched();
        dh = $urandom_range(4 * bd, 1);
        r  = 5 * bd + $urandom_range(bd - 1, 0);
        ev_v[0] = 1'b1;  ev_d[0] = 8'h96;
        ev_v[dh] = 1'b1; ev_d[dh] = 8'($urandom);
        ev_v[r] = 1'b1;  ev_d[r] = 8'($urandom);
        rst_at = r;
        exp_q.push_back(8'h96);
        n = 25 * bd;
        run(n);
        e = 0;
        for (int j = 1; j <= r; j++) if (obs_tx[j] !== model_tx(j)) e++;
        checks++;
        if (e !== 0) begin
            failures++;
            $display("FAIL rst_mid_prefix: %0d bad cycles before reset, required 0", e);
        end
        checks++;
        if (obs_rdy[r] !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_held: tx_rdy=%b before reset, required 0", obs_rdy[r]);
        end
        checks++;
        if ({obs_tx[r+1], obs_rdy[r+1], obs_done[r+1]} !== 3'b110) begin
            failures++;
            $display("FAIL rst_mid_next: TX/rdy/done=%b, required 110",
                     {obs_tx[r+1], obs_rdy[r+1], obs_done[r+1]});
        end
        e = 0;
        for (int j = r + 1; j <= n; j++)
            if ({obs_tx[j], obs_rdy[j], obs_done[j]} !== 3'b110) e++;
        checks++;
        if (e !== 0) begin
            failures++;
            $display("FAIL rst_mid_quiet: %0d non-idle cycles after reset, required 0", e);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; trmt = 1'b0; sel = 1'b0; tx_data = 8'h00; bd = BD_SMALL; rst_at = -1;
        test_reset();
        test_default_a5();
        test_len16_00();
        test_back_to_back();
        test_frame_end_load();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
